// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF measurement block.
// Holds the measurement FSM state encoding, the response record and the
// default sizing used by ro_pair_freq_comparator and ro_edge_counter.
package ro_puf_pkg;

    // Default counter width, window length (clk cycles) and synchronizer depth.
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_WINDOW      = 1024;
    localparam int DEF_SYNC_STAGES = 2;

    // Measurement sequence for one challenge.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COUNT   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // One PUF response: the response bit, tie and error flags, and whether
    // either counter saturated during the window.
    typedef struct packed {
        logic res_bit;
        logic tie;
        logic err;
        logic sat;
    } resp_t;

    // Larger of two integers, used to size the shared settle/window timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes one free-running ring-oscillator signal into clk, detects its
// rising edges on the last two synchronizer stages and counts them with a
// saturating counter. clear zeroes the counter and its sat flag; enable gates
// counting so edges outside the measurement window are ignored.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // sync_q[0] is the first (metastability-exposed) stage; higher indices are older.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   rise;

    // Rising edge: the older of the last two stages is low, the newer is high.
    // Signals faster than clk/2 alias here and are counted low.
    assign rise = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-2];

    // Next-state: shift the synchronizer, then clear or saturate-increment the counter.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ro};
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (enable && rise && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
            // The flag marks that the counter has reached its ceiling and
            // can no longer track further edges.
            if (count_q == CNT_MAX - 1'b1) begin
                sat_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the synchronizer chain is a shift register, not a RAM, so it is
        // reset with everything else; the first window after reset then starts
        // from a known level instead of whatever X the flops powered up with.
        if (rst) begin
            sync_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/ro_pair_freq_comparator.sv
// Measurement end of the ring-oscillator PUF. A challenge (sel_a, sel_b)
// picks two oscillators; each is synchronized and its rising edges counted
// over WINDOW clk cycles, and the two counts are compared into one response
// bit. Handshake: start is taken while ready=1, resp_valid pulses once with
// the response fields, which then hold until the next response or reset.
// Latency from accept at cycle T: T + SYNC_STAGES + WINDOW + 3, or T+1 for an
// invalid challenge (equal indices or an index >= NUM_RO).
//
// Optional build macro RO_PUF_DIFF_OUT_EN adds the signed resp_diff output
// (count_a - count_b, CNT_W+1 bits) for margin characterization.
module ro_pair_freq_comparator
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO      = 8,
    parameter int SEL_W       = $clog2(NUM_RO),
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel_a,
    input  logic [SEL_W-1:0]  sel_b,
    output logic              ready,
    output logic              resp_valid,
    output logic              resp_bit,
    output logic              resp_tie,
    output logic              resp_err,
    output logic              cnt_sat
`ifdef RO_PUF_DIFF_OUT_EN
    ,
    output logic signed [CNT_W:0] resp_diff
`endif
);

    // One timer serves both the settle phase and the counting window.
    localparam int               TMR_W       = $clog2(max_int(WINDOW, SYNC_STAGES) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SYNC_STAGES - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    resp_t            resp_q, resp_d;
`ifdef RO_PUF_DIFF_OUT_EN
    logic signed [CNT_W:0] diff_q, diff_d;
`endif

    logic             ro_a, ro_b;
    logic             sel_a_ok, sel_b_ok, challenge_ok;
    logic             cnt_clear, cnt_enable;
    logic [CNT_W-1:0] count_a, count_b;
    logic             sat_a, sat_b;

    // Oscillator muxes driven by the latched challenge, so they switch in CLEAR
    // and a start seen while busy cannot disturb a running measurement.
    always_comb begin
        ro_a = 1'b0;
        ro_b = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (sel_a_q == SEL_W'(i)) ro_a = ro_in[i];
            if (sel_b_q == SEL_W'(i)) ro_b = ro_in[i];
        end
    end

    // Challenge check on the incoming indices: both must name an existing
    // oscillator and they must differ.
    always_comb begin
        sel_a_ok = 1'b0;
        sel_b_ok = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (sel_a == SEL_W'(i)) sel_a_ok = 1'b1;
            if (sel_b == SEL_W'(i)) sel_b_ok = 1'b1;
        end
        challenge_ok = sel_a_ok && sel_b_ok && (sel_a != sel_b);
    end

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_a (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_a),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count_a),
        .sat    (sat_a)
    );

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .ro     (ro_b),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count_b),
        .sat    (sat_b)
    );

    // Measurement FSM: next state, timer, challenge latch and response fields.
    always_comb begin
        // NOTE: every signal written here gets its hold/idle value first, so no
        // branch of the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        tmr_d      = tmr_q;
        resp_d     = resp_q;
`ifdef RO_PUF_DIFF_OUT_EN
        diff_d     = diff_q;
`endif
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_a_d = sel_a;
                    sel_b_d = sel_b;
                    if (challenge_ok) begin
                        state_d = ST_CLEAR;
                    end else begin
                        // Invalid challenge: answer immediately with the error flag.
                        state_d = ST_DONE;
                        resp_d  = '{res_bit: 1'b0, tie: 1'b0, err: 1'b1, sat: 1'b0};
`ifdef RO_PUF_DIFF_OUT_EN
                        diff_d  = '0;
`endif
                    end
                end
            end

            ST_CLEAR: begin
                cnt_clear = 1'b1;
                tmr_d     = '0;
                state_d   = ST_SETTLE;
            end

            // Edges are not counted here: the synchronizers may still hold
            // samples of the previously selected oscillators.
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_COUNT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_COUNT: begin
                cnt_enable = 1'b1;
                if (tmr_q == WINDOW_LAST) begin
                    state_d = ST_COMPARE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            // Both saturated counters read equal, so a double saturation is a tie.
            ST_COMPARE: begin
                resp_d.res_bit = (count_a > count_b);
                resp_d.tie     = (count_a == count_b);
                resp_d.err     = 1'b0;
                resp_d.sat     = sat_a | sat_b;
`ifdef RO_PUF_DIFF_OUT_EN
                diff_d         = $signed({1'b0, count_a}) - $signed({1'b0, count_b});
`endif
                state_d        = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-run simply lands in IDLE.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // computed in the previous cycle, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            sel_a_q <= '0;
            sel_b_q <= '0;
            tmr_q   <= '0;
            resp_q  <= '0;
`ifdef RO_PUF_DIFF_OUT_EN
            diff_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            tmr_q   <= tmr_d;
            resp_q  <= resp_d;
`ifdef RO_PUF_DIFF_OUT_EN
            diff_q  <= diff_d;
`endif
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_bit   = resp_q.res_bit;
    assign resp_tie   = resp_q.tie;
    assign resp_err   = resp_q.err;
    assign cnt_sat    = resp_q.sat;
`ifdef RO_PUF_DIFF_OUT_EN
    assign resp_diff  = diff_q;
`endif

endmodule

// File: tb/tb_ro_pair_freq_comparator.sv
// Bench for ro_pair_freq_comparator. Two instances share all stimulus: one
// with CNT_W=16 and one with CNT_W=3 (to exercise saturation); both use
// WINDOW=64 and SYNC_STAGES=2. Oscillators are square waves given by a
// half-period and a phase, so the expected edge counts follow by arithmetic.
// Build with +define+RO_PUF_DIFF_OUT_EN to also check resp_diff.
module tb_ro_pair_freq_comparator;

    localparam int NUM_RO = 8;
    localparam int SEL_W  = 3;
    localparam int WIN    = 64;
    localparam int SYNC   = 2;
    localparam int LAT    = SYNC + WIN + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_RO-1:0] ro_in = '0;
    logic              start;
    logic [SEL_W-1:0]  sel_a, sel_b;

    logic ready, resp_valid, resp_bit, resp_tie, resp_err, cnt_sat;
    logic ready3, valid3, bit3, tie3, err3, sat3;
`ifdef RO_PUF_DIFF_OUT_EN
    logic signed [16:0] resp_diff;
    logic signed [3:0]  diff3;
`endif

    typedef struct {
        int cyc;
        int b;
        int tie;
        int err;
        int sat;
        int diff;
    } exp_t;

    exp_t q16[$];
    exp_t q3[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int half[NUM_RO]  = '{default: 1};
    int phase[NUM_RO] = '{default: 0};

    always #5 clk = ~clk;

    ro_pair_freq_comparator #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(16), .WINDOW(WIN), .SYNC_STAGES(SYNC)
    ) u_dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .ready(ready), .resp_valid(resp_valid), .resp_bit(resp_bit), .resp_tie(resp_tie),
        .resp_err(resp_err), .cnt_sat(cnt_sat)
`ifdef RO_PUF_DIFF_OUT_EN
        , .resp_diff(resp_diff)
`endif
    );

    ro_pair_freq_comparator #(
        .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(3), .WINDOW(WIN), .SYNC_STAGES(SYNC)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .sel_a(sel_a), .sel_b(sel_b),
        .ready(ready3), .resp_valid(valid3), .resp_bit(bit3), .resp_tie(tie3),
        .resp_err(err3), .cnt_sat(sat3)
`ifdef RO_PUF_DIFF_OUT_EN
        , .resp_diff(diff3)
`endif
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle index: during the cycle after posedge p, cyc == p+1, which is also
    // the index of the posedge that will sample inputs driven at this negedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Level of oscillator i as sampled at posedge k.
    function automatic int wv(input int i, input int k);
        return ((k + phase[i]) / half[i]) % 2;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NUM_RO; i++) ro_in[i] = (wv(i, cyc) == 1);
    end

    // Rising edges seen by the window for a challenge accepted at posedge k0:
    // the mux switches after k0, the first sample pair that counts is
    // (k0+2, k0+3) and the window covers WIN consecutive sample pairs.
    function automatic int edges(input int i, input int k0);
        int n = 0;
        for (int k = k0 + 3; k <= k0 + 2 + WIN; k++)
            if (wv(i, k - 1) == 0 && wv(i, k) == 1) n++;
        return n;
    endfunction

    function automatic exp_t model(input int sa, input int sb, input int k0, input int cw);
        exp_t e;
        int   mx = (1 << cw) - 1;
        int   ca, cb;
        if (sa == sb || sa >= NUM_RO || sb >= NUM_RO) begin
            e = '{cyc: k0 + 1, b: 0, tie: 0, err: 1, sat: 0, diff: 0};
        end else begin
            ca = edges(sa, k0);
            cb = edges(sb, k0);
            e.sat  = (ca >= mx || cb >= mx) ? 1 : 0;
            ca     = (ca > mx) ? mx : ca;
            cb     = (cb > mx) ? mx : cb;
            e.cyc  = k0 + LAT;
            e.b    = (ca > cb) ? 1 : 0;
            e.tie  = (ca == cb) ? 1 : 0;
            e.err  = 0;
            e.diff = ca - cb;
        end
        return e;
    endfunction

    // Monitors: every response pops the oldest expectation of its instance.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (q16.size() == 0) begin
                check("unexpected_valid16", 1, 0);
            end else begin
                e = q16.pop_front();
                check("latency16", cyc, e.cyc);
                check("bit16", resp_bit, e.b);
                check("tie16", resp_tie, e.tie);
                check("err16", resp_err, e.err);
                check("sat16", cnt_sat, e.sat);
`ifdef RO_PUF_DIFF_OUT_EN
                check("diff16", resp_diff, e.diff);
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid3 === 1'b1) begin
            if (q3.size() == 0) begin
                check("unexpected_valid3", 1, 0);
            end else begin
                e = q3.pop_front();
                check("latency3", cyc, e.cyc);
                check("bit3", bit3, e.b);
                check("tie3", tie3, e.tie);
                check("err3", err3, e.err);
                check("sat3", sat3, e.sat);
`ifdef RO_PUF_DIFF_OUT_EN
                check("diff3", diff3, e.diff);
`endif
            end
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Issue one challenge, push both expectations, optionally throw ignored
    // start pulses (with other indices) at the busy DUT, and check that ready
    // comes back exactly one cycle after the response.
    task automatic issue(input int sa, input int sb, input bit noise);
        int   k0, ecyc;
        exp_t e;
        wait_ready();
        start = 1'b1;
        sel_a = SEL_W'(sa);
        sel_b = SEL_W'(sb);
        k0    = cyc;
        e     = model(sa, sb, k0, 16);
        ecyc  = e.cyc;
        q16.push_back(e);
        q3.push_back(model(sa, sb, k0, 3));
        @(negedge clk);
        start = 1'b0;
        sel_a = SEL_W'($urandom_range(0, NUM_RO - 1));
        sel_b = SEL_W'($urandom_range(0, NUM_RO - 1));
        for (int n = 0; n < 3000 && ready !== 1'b1; n++) begin
            if (noise && cyc <= ecyc && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                sel_a = SEL_W'($urandom_range(0, NUM_RO - 1));
                sel_b = SEL_W'($urandom_range(0, NUM_RO - 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ready_return", cyc, ecyc + 1);
    endtask

    // Reset during COUNT: no response may follow, even for a start pulse
    // thrown in while busy; ready and the response fields return to reset values.
    task automatic abort_run();
        int k0;
        wait_ready();
        start = 1'b1;
        sel_a = 3'd2;
        sel_b = 3'd5;
        k0    = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k0 + 10) @(negedge clk);
        start = 1'b1;
        sel_a = 3'd0;
        sel_b = 3'd1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k0 + 30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_valid", resp_valid, 0);
        check("abort_bit", resp_bit, 0);
        check("abort_tie", resp_tie, 0);
        check("abort_err", resp_err, 0);
        check("abort_sat3", sat3, 0);
        repeat (LAT + 10) @(negedge clk);
        check("abort_idle", ready, 1);
    endtask

    task automatic set_wave(input int i, input int h, input int p);
        half[i]  = h;
        phase[i] = p;
    endtask

    initial begin
        int sa, sb;
        rst   = 1'b1;
        start = 1'b0;
        sel_a = '0;
        sel_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_bit", resp_bit, 0);
        check("rst_tie", resp_tie, 0);
        check("rst_err", resp_err, 0);
        check("rst_sat", cnt_sat, 0);
        check("rst_ready3", ready3, 1);

        // Directed: periods 4 vs 6, tie at equal aligned periods, invalid
        // challenge, and the fastest measurable oscillator (period 2).
        set_wave(0, 1, 0);
        set_wave(1, 4, 0);
        set_wave(2, 2, 0);
        set_wave(3, 4, 0);
        set_wave(4, 5, 1);
        set_wave(5, 3, 0);
        set_wave(6, 7, 2);
        set_wave(7, 9, 3);
        issue(2, 5, 1'b0);
        abort_run();
        issue(5, 2, 1'b1);
        issue(1, 3, 1'b0);
        issue(4, 4, 1'b0);
        issue(0, 1, 1'b0);
        issue(0, 2, 1'b1);

        // Random waves and challenges, with ignored start pulses while busy.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_RO; i++)
                set_wave(i, $urandom_range(1, 9), $urandom_range(0, 17));
            sa = $urandom_range(0, NUM_RO - 1);
            sb = ($urandom_range(0, 5) == 0) ? sa : $urandom_range(0, NUM_RO - 1);
            issue(sa, sb, 1'b1);
        end

        repeat (4) @(negedge clk);
        check("pending16", q16.size(), 0);
        check("pending3", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
